// File: rtl/trace_dump_ctrl_pkg.sv
// Shared types and default sizes for the trace dump path.
// Provides the dump FSM state enum and the NUM_CH/AW/DW defaults.
package trace_dump_ctrl_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int AW_DEF     = 9;
    localparam int DW_DEF     = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/ram_port_mux.sv
// Arbitrates the shared trace RAM port: capture engine when idle, dump reads when busy.
// Ports: busy/rd_stb/ch/rd_addr from the dump FSM, cap_* from capture, ram_* to the RAMs.
module ram_port_mux
    import trace_dump_ctrl_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              busy,
    input  logic              rd_stb,
    input  logic [1:0]        ch,
    input  logic [AW-1:0]     rd_addr,
    input  logic              cap_en,
    input  logic              cap_we,
    input  logic [AW-1:0]     cap_addr,
    output logic [NUM_CH-1:0] ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr
);

    always_comb begin
        ram_en   = '0;
        ram_we   = 1'b0;
        ram_addr = rd_addr;
        unique case (1'b1)
            !busy: begin
                ram_en   = {NUM_CH{cap_en}};
                ram_we   = cap_we;
                ram_addr = cap_addr;
            end
            rd_stb: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (int'(ch) == i) ram_en[i] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/trace_dump_ctrl.sv
// Dumps one channel's trace RAM oldest-to-newest over a valid/ready byte stream.
// Ports: dump_req/dump_ch/cap_done/trace_end control, cap_*/ram_* RAM port, tx_* stream, status pulses.
module trace_dump_ctrl
    import trace_dump_ctrl_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dump_req,
    input  logic [1:0]           dump_ch,
    input  logic                 cap_done,
    input  logic [AW-1:0]        trace_end,
    input  logic                 cap_en,
    input  logic                 cap_we,
    input  logic [AW-1:0]        cap_addr,
    output logic [NUM_CH-1:0]    ram_en,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    input  logic [NUM_CH*DW-1:0] ram_rdata,
    output logic [DW-1:0]        tx_data,
    output logic                 tx_vld,
    input  logic                 tx_rdy,
    output logic                 busy,
    output logic                 dump_done,
    output logic                 clr_cap_done,
    output logic                 dump_err
);

    localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

    dump_state_t   state;
    logic [1:0]    ch;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   cnt;
    logic [DW-1:0] rd_byte;
    logic          ch_ok;

    assign busy  = (state != IDLE);
    assign ch_ok = (int'(dump_ch) < NUM_CH);

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch) == i) rd_byte = ram_rdata[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= '0;
            rd_addr      <= '0;
            cnt          <= '0;
            tx_data      <= '0;
            tx_vld       <= 1'b0;
            dump_done    <= 1'b0;
            clr_cap_done <= 1'b0;
            dump_err     <= 1'b0;
        end else begin
            dump_done    <= 1'b0;
            clr_cap_done <= 1'b0;
            dump_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dump_req) begin
                        if (cap_done && ch_ok) begin
                            ch      <= dump_ch;
                            // oldest sample sits just past the newest
                            rd_addr <= trace_end + 1'b1;
                            cnt     <= '0;
                            state   <= READ;
                        end else begin
                            dump_err <= 1'b1;
                        end
                    end
                end
                READ: state <= LATCH;
                LATCH: begin
                    tx_data <= rd_byte;
                    tx_vld  <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (tx_rdy) begin
                        tx_vld  <= 1'b0;
                        rd_addr <= rd_addr + 1'b1;
                        cnt     <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state        <= DONE;
                            dump_done    <= 1'b1;
                            clr_cap_done <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ram_port_mux #(
        .NUM_CH (NUM_CH),
        .AW     (AW)
    ) u_mux (
        .busy     (busy),
        .rd_stb   (state == READ),
        .ch       (ch),
        .rd_addr  (rd_addr),
        .cap_en   (cap_en),
        .cap_we   (cap_we),
        .cap_addr (cap_addr),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr)
    );

endmodule

// File: doc/trace_dump_ctrl.md
Name: trace_dump_ctrl

Overview:
Sequences readout of the captured trace RAMs after a capture completes, and arbitrates the shared RAM port between the capture engine (writes) and the dump path (reads). On a dump request it reads all 2^AW samples of one channel in chronological order: oldest sample first, newest last, at trace_end. Each byte is streamed over a valid/ready handshake to the host transmit path. On completion it requests that the cap_done config bit be cleared, which re-arms capture.

Parameters:
NUM_CH, 3, number of channel trace RAMs (one RAM per channel, shared address bus)
AW, 9, RAM address width (depth 2^AW = 512)
DW, 8, sample width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
dump_req  in  1  one-cycle request to dump a channel
dump_ch  in  2  channel index for dump_req (0..NUM_CH-1)
cap_done  in  1  capture-done config bit
trace_end  in  AW  address of newest captured sample
cap_en  in  1  capture engine RAM enable
cap_we  in  1  capture engine RAM write enable
cap_addr  in  AW  capture engine RAM address
ram_en  out  NUM_CH  per-channel RAM enable
ram_we  out  1  RAM write enable (shared)
ram_addr  out  AW  RAM address (shared)
ram_rdata  in  NUM_CH*DW  flattened read data; channel i is at [i*DW +: DW]; 1-cycle read latency
tx_data  out  DW  sample byte to host
tx_vld  out  1  tx_data valid
tx_rdy  in  1  host accepts byte when tx_vld&tx_rdy
busy  out  1  dump in progress (state != IDLE)
dump_done  out  1  one-cycle pulse at end of dump
clr_cap_done  out  1  one-cycle pulse; clears cap_done bit
dump_err  out  1  one-cycle pulse; request rejected

Behaviour:
- Reset (rst_n low at posedge clk): state IDLE; all outputs 0; internal address and count cleared. Applies mid-dump: tx_vld drops on the reset edge and no dump_done or clr_cap_done is issued.
- States: IDLE, READ, LATCH, SEND, DONE.
- IDLE:
  - RAM mux passes the capture engine through: ram_en = {NUM_CH{cap_en}}, ram_we = cap_we, ram_addr = cap_addr.
  - On dump_req with cap_done=1 and dump_ch<NUM_CH: latch ch; rd_addr <= trace_end+1 (mod 2^AW); cnt <= 0; go to READ.
  - On dump_req with cap_done=0 or dump_ch>=NUM_CH: dump_err pulses the next cycle; stay in IDLE.
- READ: ram_en = one-hot(ch), ram_we = 0, ram_addr = rd_addr. Go to LATCH.
- LATCH: tx_data <= ram_rdata[ch*DW +: DW]; tx_vld <= 1. Go to SEND.
- SEND: hold tx_vld and tx_data stable until tx_rdy=1. On the accepting cycle:
  - tx_vld <= 0; rd_addr <= rd_addr+1 (wraps 2^AW-1 -> 0); cnt <= cnt+1.
  - If cnt == 2^AW-1, go to DONE; otherwise go to READ.
- DONE: dump_done=1 and clr_cap_done=1 for exactly this cycle. Go to IDLE.
- cnt is AW+1 bits; exactly 2^AW bytes are sent per dump. The last byte is read from trace_end.
- Outside IDLE, capture access is blocked: cap_* are ignored and ram_we=0. cap_done=1 guarantees capture is quiescent, so no queuing is needed.
- dump_req while busy is ignored: no error, no restart.
- Throughput: 3 cycles per byte when tx_rdy is held high.
- cap_done dropping mid-dump is ignored; the dump completes.

Decomposition:
- Shared package holds the dump_state_t enum (IDLE, READ, LATCH, SEND, DONE) and the NUM_CH/AW/DW defaults, so the capture and command blocks use the same values.
- One sub-module, ram_port_mux: the combinational arbitration mux driving ram_en/ram_we/ram_addr, selected by busy.
- The FSM, address counter and byte counter stay in the top module.

Test Plan:
1. cap_done=1, trace_end=0x0FF, RAM ch0 preloaded addr[i]=i[7:0], dump_req with dump_ch=0, tx_rdy=1 -> 512 bytes 0x00..0xFF twice, first byte from addr 0x100; dump_done and clr_cap_done pulse once, 1 cycle after the 512th accept; busy for 3*512+1 cycles.
2. trace_end=0x1FF, ch2 dump -> start address 0x000 (wrap); last byte read from 0x1FF; ram_en=3'b100 on every READ cycle.
3. tx_rdy toggled randomly -> tx_data stable while tx_vld&!tx_rdy; no byte lost or duplicated; order preserved.
4. dump_req with cap_done=0, then with dump_ch=3 -> dump_err pulses once each; busy stays 0; no RAM read issued.
5. cap_en=1, cap_we=1 while IDLE -> passed through to all RAMs; during a dump, cap_we=1 -> ram_we=0 and ram_addr equals the dump address; a second dump_req mid-dump is ignored.
6. rst_n low at byte 100 of a dump -> next cycle: IDLE, tx_vld=0, no dump_done; a fresh dump_req then restarts from trace_end+1.
